// File: rtl/uart_multi_bridge.sv
// N-channel UART receive/retransmit bridge: mid-bit sampling receivers feed
// per-destination byte FIFOs, drained by CTS-gated transmitters.
module uart_multi_bridge #(
   parameter int CH_NUM     = 2,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH_NUM-1:0] rx,
   output logic [CH_NUM-1:0] tx,
   input  logic [CH_NUM-1:0] cts,
   input  logic              route,
   output logic [CH_NUM-1:0] frame_err,
   output logic [CH_NUM-1:0] overflow
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int CW   = $clog2(DIV);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic [CH_NUM-1:0] rx_push;
   logic [7:0]        rx_byte [CH_NUM];

   genvar gi;

   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_rx
         rx_state_t     state_q, state_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic [2:0]    bit_q, bit_d;
         logic [7:0]    shift_q, shift_d;
         logic          sync1_q, sync2_q, prev_q;
         logic          ferr_q, ferr_d;
         logic          push;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_q <= 1'b1;
               sync2_q <= 1'b1;
               prev_q  <= 1'b1;
               state_q <= RX_IDLE;
               cnt_q   <= '0;
               bit_q   <= '0;
               shift_q <= '0;
               ferr_q  <= 1'b0;
            end else begin
               sync1_q <= rx[gi];
               sync2_q <= sync1_q;
               prev_q  <= sync2_q;
               state_q <= state_d;
               cnt_q   <= cnt_d;
               bit_q   <= bit_d;
               shift_q <= shift_d;
               ferr_q  <= ferr_d;
            end
         end

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            bit_d   = bit_q;
            shift_d = shift_q;
            ferr_d  = 1'b0;
            push    = 1'b0;
            case (state_q)
               RX_IDLE: begin
                  if (prev_q && !sync2_q) begin
                     state_d = RX_START;
                     cnt_d   = '0;
                  end
               end
               RX_START: begin
                  if (cnt_q == CNT_HALF) begin
                     // A start bit that is high again at mid-bit was a glitch.
                     cnt_d   = '0;
                     bit_d   = '0;
                     state_d = sync2_q ? RX_IDLE : RX_DATA;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               RX_DATA: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     shift_d = {sync2_q, shift_q[7:1]};
                     bit_d   = bit_q + 1'b1;
                     if (bit_q == 3'd7) state_d = RX_STOP;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               RX_STOP: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = RX_IDLE;
                     if (sync2_q) push = 1'b1;
                     else         ferr_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: state_d = RX_IDLE;
            endcase
         end

         assign rx_push[gi]   = push;
         assign rx_byte[gi]   = shift_q;
         assign frame_err[gi] = ferr_q;
      end

      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         // Channel feeding this destination when cross-routing is selected.
         localparam int SRC = (gi + CH_NUM - 1) % CH_NUM;

         logic          wr_en;
         logic [7:0]    wr_data;
         logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
         logic [7:0]    mem_q [FIFO_DEPTH];
         logic [7:0]    rd_data_q;
         logic          empty, full, push, pop;
         logic          ovf_q, ovf_d;

         tx_state_t     state_q, state_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic [2:0]    bit_q, bit_d;
         logic [7:0]    shift_q, shift_d;
         logic          tx_q, tx_d;

         assign wr_en   = route ? rx_push[SRC] : rx_push[gi];
         assign wr_data = route ? rx_byte[SRC] : rx_byte[gi];

         assign empty = (wr_ptr_q == rd_ptr_q);
         assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
         assign push  = wr_en && !full;

         always_comb begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
            ovf_d    = ovf_q | (wr_en & full);
         end

         always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
            if (pop)  rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               ovf_q    <= 1'b0;
               state_q  <= TX_IDLE;
               cnt_q    <= '0;
               bit_q    <= '0;
               shift_q  <= '0;
               tx_q     <= 1'b1;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               ovf_q    <= ovf_d;
               state_q  <= state_d;
               cnt_q    <= cnt_d;
               bit_q    <= bit_d;
               shift_q  <= shift_d;
               tx_q     <= tx_d;
            end
         end

         // tx_q is registered so the line level always matches state_q.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            bit_d   = bit_q;
            shift_d = shift_q;
            tx_d    = tx_q;
            pop     = 1'b0;
            case (state_q)
               TX_IDLE: begin
                  tx_d = 1'b1;
                  if (!empty && cts[gi]) begin
                     pop     = 1'b1;
                     state_d = TX_START;
                     cnt_d   = '0;
                     tx_d    = 1'b0;
                  end
               end
               TX_START: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     bit_d   = '0;
                     state_d = TX_DATA;
                     tx_d    = rd_data_q[0];
                     shift_d = {1'b1, rd_data_q[7:1]};
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               TX_DATA: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d = '0;
                     if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                     end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[7:1]};
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               TX_STOP: begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d = '0;
                     if (!empty && cts[gi]) begin
                        pop     = 1'b1;
                        state_d = TX_START;
                        tx_d    = 1'b0;
                     end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d = TX_IDLE;
                  tx_d    = 1'b1;
               end
            endcase
         end

         assign tx[gi]       = tx_q;
         assign overflow[gi] = ovf_q;
      end
   endgenerate

endmodule

// File: tb/tb_uart_multi_bridge.sv
// Scoreboard bench for uart_multi_bridge: stimulus pushes expected bytes per
// destination, independent serial monitors decode tx and compare.
module tb_uart_multi_bridge;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int DIV      = 10;
   localparam int DEPTH    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] rx = 2'b11;
   logic [1:0] cts = 2'b11;
   logic       route = 1'b0;
   logic [1:0] tx;
   logic [1:0] frame_err;
   logic [1:0] overflow;

   uart_multi_bridge #(
      .CH_NUM(2), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .cts(cts),
      .route(route), .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: ordered bytes expected per destination line.
   logic [7:0] exp_q [2][$];
   int         model_level [2];
   bit         exp_ovf [2];
   int         frames_seen [2];
   int         starts [2][$];
   int         send_cyc [2];
   int         ferr_cyc [2];
   int         rst_events = 0;

   always @(negedge rst_n) rst_events++;

   always @(negedge clk) begin
      if (frame_err[0]) ferr_cyc[0]++;
      if (frame_err[1]) ferr_cyc[1]++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic void expect_byte(input int src, input logic [7:0] b);
      int dest;
      dest = route ? (src + 1) % 2 : src;
      if (model_level[dest] < DEPTH) begin
         exp_q[dest].push_back(b);
         model_level[dest]++;
      end else begin
         exp_ovf[dest] = 1'b1;
      end
   endfunction

   task automatic send_byte(input int ch, input logic [7:0] b, input logic stop);
      @(posedge clk); #1;
      send_cyc[ch] = cyc;
      rx[ch] = 1'b0;
      repeat (DIV) @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         rx[ch] = b[i];
         repeat (DIV) @(posedge clk); #1;
      end
      rx[ch] = stop;
      repeat (DIV) @(posedge clk); #1;
      rx[ch] = 1'b1;
   endtask

   task automatic send_rand(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         logic [7:0] v;
         v = 8'($urandom);
         expect_byte(ch, v);
         send_byte(ch, v, 1'b1);
      end
   endtask

   task automatic mon(input int ch);
      logic       prev_tx;
      logic       st, sp;
      logic [7:0] d;
      logic [7:0] e;
      int         s, r0;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && prev_tx && !tx[ch]) begin
            s  = cyc;
            r0 = rst_events;
            starts[ch].push_back(s);
            if (model_level[ch] > 0) model_level[ch]--;
            repeat (DIV / 2) @(negedge clk);
            st = tx[ch];
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               d[i] = tx[ch];
            end
            repeat (DIV) @(negedge clk);
            sp = tx[ch];
            if (rst_events != r0) begin
               $display("[TB] tx%0d frame from cycle %0d cut by reset", ch, s);
            end else begin
               frames_seen[ch]++;
               if (exp_q[ch].size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL tx%0d_unexpected: got frame 0x%02h at cycle %0d, expected none", ch, d, s);
               end else begin
                  e = exp_q[ch].pop_front();
                  $display("[TB] tx%0d frame 0x%02h at cycle %0d (expected 0x%02h)", ch, d, s, e);
                  check($sformatf("tx%0d_frame", ch), int'({sp, d, st}), int'({1'b1, e, 1'b0}));
               end
            end
         end
         prev_tx = tx[ch];
      end
   endtask

   task automatic wait_frames(input int ch, input int n, input string name);
      int t = 0;
      while (frames_seen[ch] < n && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check(name, int'(frames_seen[ch] >= n), 1);
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check(name, exp_q[0].size() + exp_q[1].size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         mon(0);
         mon(1);
      join_none
   end

   initial begin
      int f0, f1, e0, e1, rel, t;

      repeat (3) @(posedge clk); #1;
      check("reset_tx", int'(tx), 3);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_overflow", int'(overflow), 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk); #1;

      // Loopback 0x55 with start-bit latency
      route = 1'b0;
      cts = 2'b11;
      expect_byte(0, 8'h55);
      send_byte(0, 8'h55, 1'b1);
      wait_frames(0, 1, "lb_wait");
      check("lb_latency", starts[0][0] - send_cyc[0], 99);
      check("lb_tx1_quiet", frames_seen[1], 0);
      check("lb_frame_err", ferr_cyc[0] + ferr_cyc[1], 0);
      check("lb_overflow", int'(overflow), 0);

      // Cross routing, simultaneous sources
      route = 1'b1;
      f0 = frames_seen[0];
      f1 = frames_seen[1];
      expect_byte(0, 8'hA3);
      expect_byte(1, 8'h3C);
      fork
         send_byte(0, 8'hA3, 1'b1);
         send_byte(1, 8'h3C, 1'b1);
      join
      wait_frames(0, f0 + 1, "cross_wait0");
      wait_frames(1, f1 + 1, "cross_wait1");
      check("cross_align", starts[0][$], starts[1][$]);
      route = 1'b0;
      repeat (20) @(posedge clk); #1;

      // Short glitch on rx[0]
      f0 = frames_seen[0];
      f1 = frames_seen[1];
      e0 = ferr_cyc[0];
      rx[0] = 1'b0;
      repeat (3) @(posedge clk); #1;
      rx[0] = 1'b1;
      repeat (200) @(posedge clk); #1;
      check("glitch_no_frame", frames_seen[0] + frames_seen[1], f0 + f1);
      check("glitch_no_ferr", ferr_cyc[0], e0);

      // Framing error: stop bit 0
      e1 = ferr_cyc[1];
      send_byte(0, 8'h7E, 1'b0);
      repeat (150) @(posedge clk); #1;
      check("ferr_pulse_width", ferr_cyc[0] - e0, 1);
      check("ferr_ch1_quiet", ferr_cyc[1], e1);
      check("ferr_no_frame", frames_seen[0], f0);

      // Overflow with cts[0] held low, then drain back-to-back
      cts[0] = 1'b0;
      starts[0].delete();
      f0 = frames_seen[0];
      for (int i = 1; i <= 6; i++) begin
         expect_byte(0, 8'(i));
         send_byte(0, 8'(i), 1'b1);
         repeat (3) @(posedge clk); #1;
         check($sformatf("ovf_after_byte%0d", i), int'(overflow[0]), int'(exp_ovf[0]));
      end
      check("ovf_held_no_tx", frames_seen[0], f0);
      cts[0] = 1'b1;
      wait_frames(0, f0 + 4, "ovf_drain_wait");
      repeat (150) @(posedge clk); #1;
      check("ovf_only_four", frames_seen[0], f0 + 4);
      for (int k = 1; k < 4; k++)
         check($sformatf("ovf_gap%0d", k), starts[0][k] - starts[0][k-1], 100);
      check("ovf_sticky", int'(overflow[0]), 1);

      // cts dropped mid-frame
      starts[0].delete();
      f0 = frames_seen[0];
      expect_byte(0, 8'h81);
      expect_byte(0, 8'h42);
      fork
         begin
            send_byte(0, 8'h81, 1'b1);
            send_byte(0, 8'h42, 1'b1);
         end
         begin
            t = 0;
            while (starts[0].size() == 0 && t < 3000) begin
               @(posedge clk);
               t++;
            end
            repeat (30) @(posedge clk); #1;
            cts[0] = 1'b0;
         end
      join
      repeat (300) @(posedge clk); #1;
      check("cts_frame_completes", frames_seen[0], f0 + 1);
      rel = cyc;
      cts[0] = 1'b1;
      wait_frames(0, f0 + 2, "cts_resume_wait");
      check("cts_resume_start", (starts[0].size() > 1) ? starts[0][1] : -1, rel + 1);

      // Reset during a transmit with bytes queued
      cts[0] = 1'b0;
      starts[0].delete();
      for (int i = 0; i < 3; i++) begin
         expect_byte(0, 8'h11 * (i + 1));
         send_byte(0, 8'h11 * (i + 1), 1'b1);
      end
      cts[0] = 1'b1;
      t = 0;
      while (starts[0].size() == 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (30) @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("rst_tx_async", int'(tx), 3);
      exp_q[0].delete();
      exp_q[1].delete();
      model_level[0] = 0;
      model_level[1] = 0;
      exp_ovf[0] = 1'b0;
      exp_ovf[1] = 1'b0;
      f0 = frames_seen[0];
      f1 = frames_seen[1];
      e0 = ferr_cyc[0] + ferr_cyc[1];
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (500) @(posedge clk); #1;
      check("rst_no_output", frames_seen[0] + frames_seen[1], f0 + f1);
      check("rst_tx_idle", int'(tx), 3);
      check("rst_overflow", int'(overflow), 0);
      check("rst_frame_err", ferr_cyc[0] + ferr_cyc[1], e0);

      // Randomised traffic against the model
      cts = 2'b11;
      for (int b = 0; b < 8; b++) begin
         int n0, n1;
         route = 1'($urandom_range(0, 1));
         n0 = $urandom_range(0, 2);
         n1 = $urandom_range(0, 2);
         repeat (4) @(posedge clk); #1;
         fork
            send_rand(0, n0);
            send_rand(1, n1);
         join
         wait_drain($sformatf("rand_drain%0d", b));
         repeat (20) @(posedge clk); #1;
      end
      check("rand_overflow", int'(overflow), int'({exp_ovf[1], exp_ovf[0]}));
      check("rand_frame_err", ferr_cyc[0] + ferr_cyc[1], e0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_multi_bridge.md
Name: uart_multi_bridge

Overview:
- Parametrised N-channel UART receive/retransmit bridge; next generation of the fixed two-channel RS422 echo top.
- Each channel has an oversampling-free mid-bit UART receiver, a per-destination byte FIFO and a UART transmitter with CTS-style gating.
- A runtime route select picks either per-channel loopback or cross-routing to the neighbouring channel.
- Sits between the RS422 transceiver pins and the rest of the car controller.

Parameters:
- CH_NUM, 2, number of channels (>=1).
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_FREQ/BAUD, integer division, must be >=4.
- FIFO_DEPTH, 16, bytes per destination FIFO. Must be a power of two, >=2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  CH_NUM  serial inputs, idle high, asynchronous to clk.
- tx  output  CH_NUM  serial outputs, idle high.
- cts  input  CH_NUM  per-channel transmit enable. 1 = a new frame may start.
- route  input  1  0 = loopback (ch i -> ch i), 1 = cross (ch i -> ch (i+1)%CH_NUM).
- frame_err  output  CH_NUM  one-cycle pulse per rejected frame.
- overflow  output  CH_NUM  sticky: a byte for destination FIFO i was dropped.

Behaviour:
- Reset (async assert, sync release): tx=all 1, frame_err=0, overflow=0, all FIFOs empty, RX/TX FSMs in IDLE, baud counters 0.
- Frame format: 8N1, LSB first, each bit DIV clk cycles.
- rx is synchronised through 2 flops; all RX decisions use the synchronised value.
- RX FSM states:
  - IDLE: falling edge detected -> START, counter cleared.
  - START: at count DIV/2-1, sample. Sample 1 -> IDLE (glitch: no byte, no error). Sample 0 -> DATA.
  - DATA: sample every DIV cycles at mid-bit, 8 bits.
  - STOP: sample at mid-bit. Sample 1 -> byte valid, push (below). Sample 0 -> frame_err[i]=1 for exactly one cycle, byte discarded.
  - After STOP -> IDLE; the next falling edge is accepted immediately.
- Routing: route is sampled in the stop-sample cycle. The destination mapping is always a permutation, so each FIFO has exactly one writer per cycle.
- FIFO push when full: byte dropped, overflow[dest] set and held until reset. FIFO contents are unchanged.
- Simultaneous push and pop on the same FIFO: both take effect and the level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- TX FSM states:
  - IDLE: pops when the FIFO is non-empty and cts[i]=1, -> START.
  - START, DATA x8, STOP: each bit held DIV cycles.
  - After STOP: if the FIFO is non-empty and cts=1, the next start bit begins the cycle after the stop bit ends (no idle gap); otherwise -> IDLE.
- cts is checked only at frame start. Deasserting cts mid-frame never truncates a frame.
- Latency: with TX IDLE, FIFO empty and cts=1, tx[dest] goes low 2 clk after the push cycle (cycle 1 pop, cycle 2 start bit).
- Reset mid-frame: tx returns to 1 asynchronously. The partial byte is lost and FIFOs are emptied.

Test Plan:
- Use CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), CH_NUM=2, FIFO_DEPTH=4 for all scenarios.
- Loopback: route=0, cts=11, send 0x55 on rx[0] -> tx[0] emits start,1,0,1,0,1,0,1,0,stop; start bit begins 2 clk after the stop-sample cycle; tx[1] stays 1; no flags set.
- Cross: route=1, send 0xA3 on rx[0] and 0x3C on rx[1] simultaneously -> tx[1] carries 0xA3 and tx[0] carries 0x3C, both frames aligned to the same cycle.
- Glitch and framing error:
  - rx[0] low for 3 clk -> no output, no flags.
  - Frame 0x7E with stop bit 0 -> frame_err[0] high for exactly 1 cycle, tx[0] stays 1.
- Overflow and flow control: cts[0]=0, send 0x01..0x06 on rx[0] -> overflow[0] set on the 5th byte. Then raise cts[0] -> tx[0] sends 0x01,0x02,0x03,0x04 back-to-back (each frame 100 clk, no gaps); overflow[0] stays 1.
- cts mid-frame: drop cts[0] during the DATA state of 0x81 -> the frame completes; a queued second byte is not sent until cts[0]=1.
- Reset mid-operation: assert rst_n during the DATA state of tx[0] with 2 bytes queued -> tx=11 immediately; after release, no further output and all flags 0.
